// File: rtl/tt_sweep_checker_if.sv
// Stimulus/result bundle between a sweep checker and the lab DUT harness around it.
// master: the checker side; slave: the harness that supplies start and dut_out.
interface tt_sweep_checker_if #(
  parameter int unsigned N = 3
);
  logic         start;
  logic         dut_out;
  logic [N-1:0] dut_in;
  logic         busy;
  logic         done;
  logic         fail;
  logic [N:0]   mismatch_cnt;
  logic [N-1:0] first_fail_vec;

  modport master (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output fail,
    output mismatch_cnt,
    output first_fail_vec
  );

  modport slave (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  fail,
    input  mismatch_cnt,
    input  first_fail_vec
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep: drives all 2^N vectors for HOLD cycles each and checks dut_out.
// Define TT_SWEEP_GRAY_EN to step through the vectors in Gray order instead of binary.
module tt_sweep_checker #(
  parameter int unsigned       N      = 3,
  parameter int unsigned       HOLD   = 20,
  parameter logic [(1<<N)-1:0] EXPECT = 8'b1110_1000
) (
  input logic                clk,
  input logic                rst,
  tt_sweep_checker_if.master bus
);

  typedef logic [N-1:0] vec_t;
  typedef logic [N:0]   cnt_t;
  typedef logic [15:0]  hold_t;

  // Index is one bit wider than the vector so the terminal compare never wraps.
  localparam cnt_t  LastIdx  = cnt_t'((1 << N) - 1);
  localparam hold_t HoldLast = hold_t'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e state_q, state_d;
  cnt_t   idx_q, idx_d;
  hold_t  hold_q, hold_d;
  vec_t   dut_in_q, dut_in_d;
  cnt_t   mism_q, mism_d;
  vec_t   first_q, first_d;

  function automatic vec_t seq(input cnt_t i);
`ifdef TT_SWEEP_GRAY_EN
    cnt_t g;
    g = i ^ (i >> 1);
    return g[N-1:0];
`else
    return i[N-1:0];
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    dut_in_d = dut_in_q;
    mism_d   = mism_q;
    first_d  = first_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StDrive;
          idx_d    = '0;
          hold_d   = '0;
          dut_in_d = seq('0);
          mism_d   = '0;
          first_d  = '0;
        end
      end
      StDrive: begin
        // start is deliberately not looked at here: a running sweep cannot be restarted.
        if (hold_q == HoldLast) begin
          if (bus.dut_out != EXPECT[dut_in_q]) begin
            mism_d = mism_q + 1'b1;
            if (mism_q == '0) first_d = dut_in_q;
          end
          if (idx_q < LastIdx) begin
            idx_d    = idx_q + 1'b1;
            dut_in_d = seq(idx_q + 1'b1);
            hold_d   = '0;
          end else begin
            state_d = StDone;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      hold_q   <= '0;
      dut_in_q <= '0;
      mism_q   <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      dut_in_q <= dut_in_d;
      mism_q   <= mism_d;
      first_q  <= first_d;
    end
  end

  logic done;
  assign done               = (state_q == StDone);
  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = (state_q == StDrive);
  assign bus.done           = done;
  assign bus.fail           = done && (mism_q != '0);
  assign bus.mismatch_cnt   = mism_q;
  assign bus.first_fail_vec = first_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: a majority DUT (N=3, HOLD=20) and an XOR DUT (N=2, HOLD=1).
// Expected vectors are queued at start and popped as each vector is presented.
module tb_tt_sweep_checker;

  localparam int unsigned NA    = 3;
  localparam int unsigned HA    = 20;
  localparam int unsigned NB    = 2;
  localparam int unsigned HB    = 1;
  localparam logic [7:0]  EXP_A = 8'b1110_1000;
  localparam logic [3:0]  EXP_B = 4'b0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  tt_sweep_checker_if #(.N(NA)) bus_a ();
  tt_sweep_checker_if #(.N(NB)) bus_b ();

  tt_sweep_checker #(.N(NA), .HOLD(HA), .EXPECT(EXP_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  tt_sweep_checker #(.N(NB), .HOLD(HB), .EXPECT(EXP_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  // Lab DUT models, with an optional single-vector output inversion.
  logic          inj_a_en  = 1'b0;
  logic [NA-1:0] inj_a_vec = '0;
  logic          inj_b_en  = 1'b0;
  logic [NB-1:0] inj_b_vec = '0;

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_comb bus_a.dut_out = maj(bus_a.dut_in) ^ (inj_a_en && (bus_a.dut_in == inj_a_vec));
  always_comb bus_b.dut_out = (^bus_b.dut_in) ^ (inj_b_en && (bus_b.dut_in == inj_b_vec));

  function automatic int unsigned seq_model(input int unsigned i);
`ifdef TT_SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus_a.dut_in, bus_a.busy, bus_a.done, bus_a.fail, bus_a.mismatch_cnt,
         bus_a.first_fail_vec} !== '0) begin
      fails++;
      $display("FAIL reset_a: dut_in=%0d busy=%b done=%b fail=%b mis=%0d first=%0d, want all 0",
               bus_a.dut_in, bus_a.busy, bus_a.done, bus_a.fail, bus_a.mismatch_cnt,
               bus_a.first_fail_vec);
    end
    tests++;
    if ({bus_b.dut_in, bus_b.busy, bus_b.done, bus_b.fail, bus_b.mismatch_cnt,
         bus_b.first_fail_vec} !== '0) begin
      fails++;
      $display("FAIL reset_b: dut_in=%0d busy=%b done=%b fail=%b mis=%0d first=%0d, want all 0",
               bus_b.dut_in, bus_b.busy, bus_b.done, bus_b.fail, bus_b.mismatch_cnt,
               bus_b.first_fail_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus_a.busy, bus_a.done);
    end
  endtask

  // Full majority sweep; restart_j >= 0 pulses start so it lands on edge restart_j+1.
  task automatic test_majority_sweep(input string name, input bit inj, input int unsigned ivec,
                                     input int restart_j);
    logic [NA-1:0] exp_q[$];
    logic [NA-1:0] s, cur, prev;
    int unsigned   total;
    int unsigned   exp_mis;
    logic [NA-1:0] exp_first;
    total     = (1 << NA) * HA;
    exp_mis   = 0;
    exp_first = '0;
    cur       = '0;
    inj_a_en  = inj;
    inj_a_vec = NA'(ivec);
    for (int unsigned v = 0; v < (1 << NA); v++) begin
      s = NA'(seq_model(v));
      exp_q.push_back(s);
      if ((maj(s) ^ (inj && (s == NA'(ivec)))) != EXP_A[s]) begin
        if (exp_mis == 0) exp_first = s;
        exp_mis++;
      end
    end
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    for (int unsigned j = 0; j < total; j++) begin
      if (j % HA == 0) begin
        prev = cur;
        cur  = exp_q.pop_front();
`ifdef TT_SWEEP_GRAY_EN
        if (j > 0) begin
          tests++;
          if ($countones(bus_a.dut_in ^ prev) != 1) begin
            fails++;
            $display("FAIL %s gray_step j=%0d: %0d -> %0d, want one-bit change",
                     name, j, prev, bus_a.dut_in);
          end
        end
`endif
      end
      tests++;
      if (bus_a.dut_in !== cur || bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin
        fails++;
        $display("FAIL %s drive j=%0d: dut_in=%0d busy=%b done=%b, want dut_in=%0d busy=1 done=0",
                 name, j, bus_a.dut_in, bus_a.busy, bus_a.done, cur);
      end
      bus_a.start = (int'(j) == restart_j);
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
    end
    tests++;
    if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.fail !== (exp_mis != 0) ||
        bus_a.mismatch_cnt !== (NA+1)'(exp_mis) || bus_a.first_fail_vec !== exp_first ||
        bus_a.dut_in !== cur) begin
      fails++;
      $display("FAIL %s result: done=%b busy=%b fail=%b mis=%0d first=%0d dut_in=%0d, want 1 0 %b %0d %0d %0d",
               name, bus_a.done, bus_a.busy, bus_a.fail, bus_a.mismatch_cnt,
               bus_a.first_fail_vec, bus_a.dut_in, exp_mis != 0, exp_mis, exp_first, cur);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.dut_in !== cur) begin
      fails++;
      $display("FAIL %s done_hold: done=%b busy=%b dut_in=%0d, want 1 0 %0d",
               name, bus_a.done, bus_a.busy, bus_a.dut_in, cur);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s queue: %0d left, want 0", name, exp_q.size());
    end
    inj_a_en = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    repeat (4 * HA + 5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus_a.dut_in, bus_a.busy, bus_a.done, bus_a.fail, bus_a.mismatch_cnt,
         bus_a.first_fail_vec} !== '0) begin
      fails++;
      $display("FAIL mid_reset: dut_in=%0d busy=%b done=%b fail=%b mis=%0d first=%0d, want all 0",
               bus_a.dut_in, bus_a.busy, bus_a.done, bus_a.fail, bus_a.mismatch_cnt,
               bus_a.first_fail_vec);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL post_reset_idle: busy/done rose without start, want idle");
    end
  endtask

  // Three back-to-back XOR sweeps; the middle one has an injected error so the third
  // shows counts are cleared by a restart from DONE.
  task automatic test_xor_hold1();
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] s, cur;
    int unsigned   exp_mis;
    logic [NB-1:0] exp_first;
    for (int run = 0; run < 3; run++) begin
      inj_b_en  = (run == 1);
      inj_b_vec = 2'd2;
      exp_mis   = 0;
      exp_first = '0;
      cur       = '0;
      for (int unsigned v = 0; v < (1 << NB); v++) begin
        s = NB'(seq_model(v));
        exp_q.push_back(s);
        if (((^s) ^ (inj_b_en && (s == inj_b_vec))) != EXP_B[s]) begin
          if (exp_mis == 0) exp_first = s;
          exp_mis++;
        end
      end
      @(negedge clk);
      bus_b.start = 1'b1;
      @(posedge clk);
      #1;
      bus_b.start = 1'b0;
      for (int unsigned j = 0; j < (1 << NB) * HB; j++) begin
        if (j % HB == 0) cur = exp_q.pop_front();
        tests++;
        if (bus_b.dut_in !== cur || bus_b.busy !== 1'b1 ||
            (j == 0 && bus_b.mismatch_cnt !== '0)) begin
          fails++;
          $display("FAIL xor run%0d j=%0d: dut_in=%0d busy=%b mis=%0d, want %0d 1",
                   run, j, bus_b.dut_in, bus_b.busy, bus_b.mismatch_cnt, cur);
        end
        @(posedge clk);
        #1;
      end
      tests++;
      if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0 || bus_b.fail !== (exp_mis != 0) ||
          bus_b.mismatch_cnt !== (NB+1)'(exp_mis) || bus_b.first_fail_vec !== exp_first) begin
        fails++;
        $display("FAIL xor run%0d result: done=%b busy=%b fail=%b mis=%0d first=%0d, want 1 0 %b %0d %0d",
                 run, bus_b.done, bus_b.busy, bus_b.fail, bus_b.mismatch_cnt,
                 bus_b.first_fail_vec, exp_mis != 0, exp_mis, exp_first);
      end
      repeat (2) @(posedge clk);
    end
    inj_b_en = 1'b0;
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    test_reset();
    test_majority_sweep("maj_clean", 1'b0, 0, -1);
    test_majority_sweep("maj_inj3", 1'b1, 3, -1);
    test_majority_sweep("maj_inj5", 1'b1, 5, -1);
    test_xor_hold1();
    test_reset_mid_sweep();
    test_majority_sweep("maj_after_reset", 1'b0, 0, -1);
    test_majority_sweep("maj_start_busy", 1'b0, 0, 2 * HA + 3);
    test_majority_sweep("maj_start_last", 1'b1, 6, (1 << NA) * HA - 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Parametrised, self-checking exhaustive stimulus engine for small combinational lab blocks.
- Drives every one of the 2^N input combinations to a DUT and holds each for HOLD clock cycles.
- Compares the DUT's 1-bit output against a truth-table parameter and reports the mismatch count and the first failing vector.
- Sits beside the DUT inside a lab top or bench. It replaces hand-written per-vector initial blocks with a clocked sweep that works for any input width.

Parameters:
- N, 3, DUT input width in bits; legal range 1..8.
- HOLD, 20, clock cycles each vector is held; legal range 1..65535.
- EXPECT, 8'b1110_1000, expected DUT output as a 2^N-bit truth table; bit i is the expected output for input value i.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a sweep
- dut_out  input  1  DUT output under test
- dut_in  output  N  registered stimulus to the DUT
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep end until the next start or reset
- fail  output  1  high with done when mismatch_cnt is nonzero
- mismatch_cnt  output  N+1  number of vectors whose sample did not match EXPECT
- first_fail_vec  output  N  input value of the first mismatching vector; 0 if none

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - dut_in, busy, done, fail, mismatch_cnt and first_fail_vec all go to 0.
  - The hold counter and sequence index clear.
- State machine:
  - IDLE: start=1 -> DRIVE. On that edge: index=0, dut_in=seq(0), hold_cnt=0, mismatch_cnt=0, first_fail_vec=0, busy=1, done=0, fail=0.
  - DRIVE: hold_cnt increments each cycle. When hold_cnt==HOLD-1, dut_out is sampled on that edge and compared with EXPECT[dut_in].
    - Mismatch: mismatch_cnt increments. If it was 0 before the increment, first_fail_vec=dut_in.
    - If index < 2^N-1: index increments, dut_in=seq(index+1), hold_cnt=0, stay in DRIVE.
    - Else -> DONE.
  - DONE: busy=0, done=1, fail=(final mismatch_cnt!=0); dut_in holds its last vector. start=1 -> behaves exactly as start in IDLE (restart).
- Timing:
  - Each vector is presented for exactly HOLD cycles.
  - Total sweep length is 2^N*HOLD cycles from the start edge to the done edge.
  - The DUT is combinational, so sampling in the last hold cycle gives at least HOLD-1 cycles of settling.
- Boundary conditions:
  - start while busy: ignored; the sweep is not restarted.
  - HOLD=1: sample every cycle; one vector per cycle.
  - mismatch_cnt is N+1 bits wide, so a count of 2^N (all vectors failing) is representable; no saturation logic.
  - Index uses N+1 bits internally so the terminal compare does not wrap.
  - rst asserted mid-sweep: outputs clear immediately and asynchronously; no done pulse; start is required afterwards.
  - start and the final sample on the same edge in DRIVE: start is ignored; the block goes to DONE.
- Sequence: seq(i)=i (binary count 0..2^N-1).

Optional Feature:
- Macro: TT_SWEEP_GRAY_EN.
- Defined: seq(i)=i^(i>>1) (Gray order), so exactly one dut_in bit changes per vector step.
  - The EXPECT lookup still uses the actual dut_in value.
  - first_fail_vec reports the actual dut_in value, not the index.
- Undefined: binary order as above; no Gray logic is synthesised.

Test Plan:
- Majority DUT (N=3, HOLD=20, EXPECT=8'b1110_1000), start at cycle 5 -> dut_in steps 0..7 every 20 cycles; done=1 at cycle 165; mismatch_cnt=0; fail=0.
- Same config with DUT output forced inverted for input 3 only -> done, fail=1, mismatch_cnt=1, first_fail_vec=3.
- N=2, HOLD=1, EXPECT=4'b0110, DUT = XOR of its inputs -> dut_in changes every cycle; done 4 cycles after start; mismatch_cnt=0. Then a second start from DONE re-sweeps and clears the counts.
- rst pulsed during vector 4 of the majority sweep -> all outputs 0 within the same cycle; no done. A later start completes a clean full sweep.
- start pulsed again at vector 2 while busy -> ignored; total sweep length unchanged at 160 cycles.
- TT_SWEEP_GRAY_EN defined, N=3 -> dut_in sequence 0,1,3,2,6,7,5,4; Hamming distance 1 per step. Majority check passes. An error injected at input 5 gives first_fail_vec=5.
